password_box_ctrl: RTL and testbench
====================================

# password_box_ctrl

Password-entry controller fed directly by the 4x4 keypad row scanner. It watches the scanner's column lines and latched key code, and debounces presses into single key events. A PW_LEN-digit code entered against a stored password unlocks the box; repeated failures raise a latched alarm. When unlocked, the password can be changed from the keypad.

## Interface
- DEBOUNCE_WIN, 4: consecutive 4-clock scan windows of stable press/release state required before the debounced state changes.
- PW_LEN, 4: password length in digits (1..8).
- MAX_FAIL, 3: failed attempts that trigger the alarm.
- DEFAULT_PW, 16'h1234: reset password, one nibble per digit, first-entered digit in the most significant nibble; width 4*PW_LEN.
- clk  in  1  system clock, same clock as the row scanner.
- rst  in  1  synchronous, active-high reset.
- SWC  in  4  keypad column lines, active-low, shared with the scanner.
- key  in  4  scanner's latched key code.
- key_evt  out  1  one-cycle pulse per debounced press.
- key_code  out  4  code captured with key_evt; held until the next event.
- digit_cnt  out  4  digits currently in the entry buffer.
- unlocked  out  1  high in OPEN and SETPW.
- alarm  out  1  high in ALARM.
- err  out  1  one-cycle pulse on a rejected key or a failed check.

## Operation
- Press detector:
  - A free-running 2-bit window counter splits time into 4-clock windows, one per scanned row.
  - win_down = any SWC bit low during the window, evaluated at the window's last clock.
  - A stability counter counts consecutive windows with equal win_down. When it reaches DEBOUNCE_WIN and win_down differs from the debounced state, the debounced state takes win_down and the counter restarts.
  - Debounced 0->1 transition: key_evt pulses for one cycle and key_code <= key.
  - Release is debounced the same way. A held key produces exactly one event.
- Key map: 0x0-0x9 digits, 0xA enter, 0xB clear, 0xC set-password, 0xD lock, 0xE abort, 0xF unused.
- The entry buffer is a shift register of PW_LEN nibbles. A digit shifts in at the LSB nibble and digit_cnt increments.
- A digit arriving when digit_cnt==PW_LEN is dropped and pulses err.
- FSM, evaluated only on key_evt:
  - LOCKED:
    - digit: accepted into the buffer.
    - 0xB: clear buffer.
    - 0xA with digit_cnt==PW_LEN and buffer==password: go to OPEN, fail_cnt<=0.
    - Any other 0xA: pulse err, clear buffer, fail_cnt+1. Reaching MAX_FAIL goes to ALARM.
    - 0xC-0xF: pulse err.
  - OPEN:
    - 0xD: go to LOCKED.
    - 0xC: go to SETPW, clear buffer.
    - Any other key: pulse err.
  - SETPW:
    - digit: accepted into the buffer.
    - 0xB: clear buffer.
    - 0xA with digit_cnt==PW_LEN: password<=buffer, go to OPEN.
    - 0xA short: pulse err, stay in SETPW.
    - 0xE: go to OPEN, password unchanged.
    - Others: pulse err.
  - ALARM: all keys ignored with no err. Only rst exits.
- The entry buffer is cleared on every state change.

## Timing
- Reset values:
  - FSM state LOCKED; password DEFAULT_PW; buffer, digit_cnt and fail_cnt 0.
  - key_evt, err, unlocked and alarm 0; key_code 0.
  - Debounced state released; window and stability counters 0.
- Reset takes priority over every other event in the same cycle. Reset during entry discards all partial input, and a password changed before reset reverts to DEFAULT_PW.
- Press latency: with the press asserted from the first clock of a window, key_evt rises 4*DEBOUNCE_WIN clocks after that window starts, plus 1 clock for the output register.
- FSM outputs, counters and err update on the clock edge after key_evt: one-cycle latency.
- fail_cnt saturates at MAX_FAIL. digit_cnt never exceeds PW_LEN.
- A glitch shorter than DEBOUNCE_WIN windows produces no event.

## Structure
- password_box_pkg holds:
  - the state enum (LOCKED, OPEN, SETPW, ALARM);
  - key-code constants (KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_SET=4'hC, KEY_LOCK=4'hD, KEY_ABORT=4'hE).
- Sub-module keypad_press_detect contains the window counter, debounce and key capture, and outputs key_evt and key_code. The top level contains the FSM, buffer and password registers.

## Test plan
- After reset, press 1,2,3,4,A (each held for 8 windows, released for 8 windows) -> unlocked=1 one cycle after the fifth key_evt, fail_cnt=0.
- Enter 1,2,3,5,A three times -> three err pulses, alarm=1 after the third attempt. A further 1,2,3,4,A leaves alarm=1 and unlocked=0.
- Unlock, then C,9,8,7,6,A,D -> LOCKED. 1,2,3,4,A fails with err; 9,8,7,6,A unlocks.
- Enter 1,2,3,4,5 -> err on the fifth digit, digit_cnt=4. Then B -> digit_cnt=0.
- SWC low for 2 windows only (DEBOUNCE_WIN=4) -> no key_evt. Key held for 100 windows -> exactly one key_evt.
- Assert rst after 1,2 are entered, and after a password change -> digit_cnt=0, state LOCKED, DEFAULT_PW restored.

Source files
------------

// File: rtl/password_box_pkg.sv
// Shared types and key-code constants for the keypad password box.
package password_box_pkg;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    OPEN   = 2'd1,
    SETPW  = 2'd2,
    ALARM  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_SET   = 4'hC;
  localparam logic [3:0] KEY_LOCK  = 4'hD;
  localparam logic [3:0] KEY_ABORT = 4'hE;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'h9);
  endfunction

endpackage

// File: rtl/password_box_ctrl_if.sv
// Keypad-side and status signals of the password box, bundled for the top level.
interface password_box_ctrl_if;
  logic [3:0] SWC;
  logic [3:0] key;
  logic       key_evt;
  logic [3:0] key_code;
  logic [3:0] digit_cnt;
  logic       unlocked;
  logic       alarm;
  logic       err;

  modport slave (
    input  SWC, key,
    output key_evt, key_code, digit_cnt, unlocked, alarm, err
  );

  modport master (
    output SWC, key,
    input  key_evt, key_code, digit_cnt, unlocked, alarm, err
  );
endinterface

// File: rtl/password_box_ctrl_keypad_press_detect.sv
// Turns the scanner's column lines into debounced single press events,
// judging press state once per 4-clock scan window.
module keypad_press_detect #(
  parameter int DEBOUNCE_WIN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] swc,
  input  logic [3:0] key,
  output logic       key_evt,
  output logic [3:0] key_code
);

  localparam int CW = $clog2(DEBOUNCE_WIN + 1);
  localparam logic [CW-1:0] WIN_LIMIT = CW'(DEBOUNCE_WIN);

  logic [1:0]    win_cnt_r;
  logic          down_acc_r;
  logic          last_down_r;
  logic [CW-1:0] stab_cnt_r;
  logic          deb_r;
  logic          deb_d_r;
  logic          key_evt_r;
  logic [3:0]    key_code_r;

  logic          win_end_s;
  logic          win_down_s;
  logic [CW-1:0] stab_nxt_s;
  logic          stab_hit_s;

  // Window verdict and stability counter next value
  always_comb begin
    win_end_s  = (win_cnt_r == 2'd3);
    win_down_s = down_acc_r | ~(&swc);
    stab_nxt_s = stab_cnt_r;
    if (win_down_s == last_down_r) begin
      if (stab_cnt_r == WIN_LIMIT) begin
        stab_nxt_s = stab_cnt_r;
      end else begin
        stab_nxt_s = stab_cnt_r + CW'(1);
      end
    end else begin
      stab_nxt_s = CW'(1);
    end
    stab_hit_s = (stab_nxt_s == WIN_LIMIT) && (win_down_s != deb_r);
  end

  // Window counter, debounce state and event capture
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_r   <= 2'd0;
      down_acc_r  <= 1'b0;
      last_down_r <= 1'b0;
      stab_cnt_r  <= '0;
      deb_r       <= 1'b0;
      deb_d_r     <= 1'b0;
      key_evt_r   <= 1'b0;
      key_code_r  <= 4'h0;
    end else begin
      win_cnt_r <= win_cnt_r + 2'd1;
      if (win_end_s) begin
        down_acc_r  <= 1'b0;
        last_down_r <= win_down_s;
        if (stab_hit_s) begin
          deb_r      <= win_down_s;
          stab_cnt_r <= '0;
        end else begin
          stab_cnt_r <= stab_nxt_s;
        end
      end else begin
        down_acc_r <= win_down_s;
      end
      // Edge detect on the registered debounced state adds the output stage
      deb_d_r   <= deb_r;
      key_evt_r <= deb_r & ~deb_d_r;
      if (deb_r & ~deb_d_r) begin
        key_code_r <= key;
      end
    end
  end

  assign key_evt  = key_evt_r;
  assign key_code = key_code_r;

endmodule

// File: rtl/password_box_ctrl.sv
// Password box: debounced keypad events drive an entry buffer and a
// lock/open/set-password/alarm state machine.
module password_box_ctrl
  import password_box_pkg::*;
#(
  parameter int DEBOUNCE_WIN = 4,
  parameter int PW_LEN       = 4,
  parameter int MAX_FAIL     = 3,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW = 16'h1234
) (
  input logic               clk,
  input logic               rst,
  password_box_ctrl_if.slave bus
);

  localparam int BW = 4 * PW_LEN;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);
  localparam logic [3:0]    FULL_CNT   = 4'(PW_LEN);

  localparam logic [1:0] S_LOCKED = LOCKED;
  localparam logic [1:0] S_OPEN   = OPEN;
  localparam logic [1:0] S_SETPW  = SETPW;
  localparam logic [1:0] S_ALARM  = ALARM;

  logic          evt_s;
  logic [3:0]    code_s;

  logic [1:0]    state_r, state_nxt_s;
  logic [BW-1:0] pw_r, pw_nxt_s;
  logic [BW-1:0] buf_r, buf_nxt_s, shift_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  logic [FW-1:0] fail_r, fail_nxt_s;
  logic          err_s;
  logic          full_s;
  logic          err_r, unlocked_r, alarm_r;

  keypad_press_detect #(
    .DEBOUNCE_WIN(DEBOUNCE_WIN)
  ) u_detect (
    .clk     (clk),
    .rst     (rst),
    .swc     (bus.SWC),
    .key     (bus.key),
    .key_evt (evt_s),
    .key_code(code_s)
  );

  // Next-state, buffer and password update on each key event
  always_comb begin
    state_nxt_s = state_r;
    pw_nxt_s    = pw_r;
    buf_nxt_s   = buf_r;
    cnt_nxt_s   = cnt_r;
    fail_nxt_s  = fail_r;
    err_s       = 1'b0;
    full_s      = (cnt_r == FULL_CNT);
    shift_s     = (buf_r << 4) | BW'(code_s);

    if (evt_s) begin
      case (state_r)
        S_LOCKED: begin
          if (is_digit(code_s)) begin
            if (full_s) begin
              err_s = 1'b1;
            end else begin
              buf_nxt_s = shift_s;
              cnt_nxt_s = cnt_r + 4'd1;
            end
          end else if (code_s == KEY_CLEAR) begin
            buf_nxt_s = '0;
            cnt_nxt_s = 4'd0;
          end else if (code_s == KEY_ENTER) begin
            if (full_s && (buf_r == pw_r)) begin
              state_nxt_s = S_OPEN;
              fail_nxt_s  = '0;
            end else begin
              err_s     = 1'b1;
              buf_nxt_s = '0;
              cnt_nxt_s = 4'd0;
              if (fail_r >= FAIL_LIMIT) begin
                fail_nxt_s = fail_r;
              end else begin
                fail_nxt_s = fail_r + FW'(1);
              end
              if (fail_nxt_s >= FAIL_LIMIT) begin
                state_nxt_s = S_ALARM;
              end else begin
                state_nxt_s = S_LOCKED;
              end
            end
          end else begin
            err_s = 1'b1;
          end
        end
        S_OPEN: begin
          if (code_s == KEY_LOCK) begin
            state_nxt_s = S_LOCKED;
          end else if (code_s == KEY_SET) begin
            state_nxt_s = S_SETPW;
          end else begin
            err_s = 1'b1;
          end
        end
        S_SETPW: begin
          if (is_digit(code_s)) begin
            if (full_s) begin
              err_s = 1'b1;
            end else begin
              buf_nxt_s = shift_s;
              cnt_nxt_s = cnt_r + 4'd1;
            end
          end else if (code_s == KEY_CLEAR) begin
            buf_nxt_s = '0;
            cnt_nxt_s = 4'd0;
          end else if (code_s == KEY_ENTER) begin
            if (full_s) begin
              pw_nxt_s    = buf_r;
              state_nxt_s = S_OPEN;
            end else begin
              err_s = 1'b1;
            end
          end else if (code_s == KEY_ABORT) begin
            state_nxt_s = S_OPEN;
          end else begin
            err_s = 1'b1;
          end
        end
        S_ALARM: begin
          state_nxt_s = S_ALARM;
        end
        default: begin
          state_nxt_s = S_LOCKED;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end

    // Any state change starts the next entry from an empty buffer
    if (state_nxt_s != state_r) begin
      buf_nxt_s = '0;
      cnt_nxt_s = 4'd0;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // Controller state and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_LOCKED;
      pw_r       <= DEFAULT_PW;
      buf_r      <= '0;
      cnt_r      <= 4'd0;
      fail_r     <= '0;
      err_r      <= 1'b0;
      unlocked_r <= 1'b0;
      alarm_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pw_r       <= pw_nxt_s;
      buf_r      <= buf_nxt_s;
      cnt_r      <= cnt_nxt_s;
      fail_r     <= fail_nxt_s;
      err_r      <= err_s;
      unlocked_r <= (state_nxt_s == S_OPEN) || (state_nxt_s == S_SETPW);
      alarm_r    <= (state_nxt_s == S_ALARM);
    end
  end

  assign bus.key_evt   = evt_s;
  assign bus.key_code  = code_s;
  assign bus.digit_cnt = cnt_r;
  assign bus.unlocked  = unlocked_r;
  assign bus.alarm     = alarm_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_password_box_ctrl.sv
// Directed bench for password_box_ctrl: table of key presses with expected
// status after each, plus hand-written debounce, latency and reset sequences.
module tb_password_box_ctrl;

  typedef struct {
    logic       rb;
    logic [3:0] k;
    logic       e;
    logic       u;
    logic       a;
    logic [3:0] c;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   evt_seen = 0;
  int   err_seen = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  password_box_ctrl_if bus ();

  password_box_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (bus.key_evt) evt_seen <= evt_seen + 1;
    if (bus.err)     err_seen <= err_seen + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rb, input logic [3:0] k, input logic e,
                     input logic u, input logic a, input logic [3:0] c);
    vec_t v;
    v.rb = rb; v.k = k; v.e = e; v.u = u; v.a = a; v.c = c;
    tbl.push_back(v);
  endtask

  // Press with LOCKED-state digits expected accepted, no err
  task automatic add_digits(input logic [3:0] d0, d1, d2, d3, input logic u, input logic a,
                            input logic acc);
    add(1'b0, d0, 1'b0, u, a, acc ? 4'd1 : 4'd0);
    add(1'b0, d1, 1'b0, u, a, acc ? 4'd2 : 4'd0);
    add(1'b0, d2, 1'b0, u, a, acc ? 4'd3 : 4'd0);
    add(1'b0, d3, 1'b0, u, a, acc ? 4'd4 : 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.SWC = 4'hF;
    bus.key = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] k, input int hold_w, input int rel_w);
    bus.key = k;
    bus.SWC = 4'b1101;
    repeat (hold_w * 4) @(negedge clk);
    bus.SWC = 4'hF;
    repeat (rel_w * 4) @(negedge clk);
  endtask

  initial begin
    int e0, r0;
    rst     = 1'b1;
    bus.SWC = 4'hF;
    bus.key = 4'h0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst key_evt", 8'(bus.key_evt), 8'd0);
    chk("rst key_code", 8'(bus.key_code), 8'd0);
    chk("rst digit_cnt", 8'(bus.digit_cnt), 8'd0);
    chk("rst unlocked", 8'(bus.unlocked), 8'd0);
    chk("rst alarm", 8'(bus.alarm), 8'd0);
    chk("rst err", 8'(bus.err), 8'd0);

    // Press latency from the first clock of a window
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    bus.SWC = 4'b1110;
    bus.key = 4'h1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 16) chk("lat evt early", 8'(bus.key_evt), 8'd0);
      if (n == 17) begin
        chk("lat evt rise", 8'(bus.key_evt), 8'd1);
        chk("lat key_code", 8'(bus.key_code), 8'h1);
      end
      if (n == 18) chk("lat evt pulse", 8'(bus.key_evt), 8'd0);
    end
    repeat (14) @(negedge clk);
    bus.SWC = 4'hF;
    repeat (32) @(negedge clk);
    chk("lat digit_cnt", 8'(bus.digit_cnt), 8'd1);
    press(4'h2, 8, 8);
    chk("partial digit_cnt", 8'(bus.digit_cnt), 8'd2);
    do_reset();
    @(negedge clk);
    chk("partial rst digit_cnt", 8'(bus.digit_cnt), 8'd0);
    chk("partial rst unlocked", 8'(bus.unlocked), 8'd0);

    // Short glitch gives no event
    e0 = evt_seen;
    bus.key = 4'h3;
    bus.SWC = 4'b0111;
    repeat (8) @(negedge clk);
    bus.SWC = 4'hF;
    repeat (40) @(negedge clk);
    chk("glitch evt count", 8'(evt_seen - e0), 8'd0);
    chk("glitch digit_cnt", 8'(bus.digit_cnt), 8'd0);

    // Long hold gives exactly one event
    e0 = evt_seen;
    press(4'h5, 100, 8);
    chk("hold evt count", 8'(evt_seen - e0), 8'd1);
    chk("hold digit_cnt", 8'(bus.digit_cnt), 8'd1);

    // Key table: rb, key, err, unlocked, alarm, digit_cnt
    add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 4'd1);
    add(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 4'd2);
    add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 4'd4);
    add(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int t = 0; t < 3; t++) begin
      add_digits(4'h1, 4'h2, 4'h3, 4'h5, 1'b0, 1'b0, 1'b1);
      add(1'b0, 4'hA, 1'b1, 1'b0, (t == 2) ? 1'b1 : 1'b0, 4'd0);
    end
    add_digits(4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 4'd1);
    add(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 4'd2);
    add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 4'd4);
    add(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'hC, 1'b0, 1'b1, 1'b0, 4'd0);
    add_digits(4'h9, 4'h8, 4'h7, 4'h6, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 4'd4);
    add(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 4'd0);
    add_digits(4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'd0);
    add_digits(4'h9, 4'h8, 4'h7, 4'h6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'hC, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 4'd1);
    add(1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 4'd1);
    add(1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 4'd0);
    add_digits(4'h9, 4'h8, 4'h7, 4'h6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int t = 0; t < 2; t++) begin
      add_digits(4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'd0);
    end
    add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 4'd1);
    add(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 4'd2);
    add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 4'd4);
    add(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 4'd0);
    add_digits(4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 4'd4);
    add(1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 4'd0);
    add(1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 4'd1);
    add(1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rb) do_reset();
      e0 = evt_seen;
      r0 = err_seen;
      press(tbl[i].k, 8, 8);
      n_vec++;
      if ((evt_seen - e0) != 1) begin
        n_fail++;
        $display("FAIL v%0d evt count: got %0d expected 1", i, evt_seen - e0);
      end
      if (bus.key_code !== tbl[i].k) begin
        n_fail++;
        $display("FAIL v%0d key_code: got %0h expected %0h", i, bus.key_code, tbl[i].k);
      end
      if ((err_seen - r0) != int'(tbl[i].e)) begin
        n_fail++;
        $display("FAIL v%0d err pulses: got %0d expected %0d", i, err_seen - r0, tbl[i].e);
      end
      if (bus.unlocked !== tbl[i].u) begin
        n_fail++;
        $display("FAIL v%0d unlocked: got %0b expected %0b", i, bus.unlocked, tbl[i].u);
      end
      if (bus.alarm !== tbl[i].a) begin
        n_fail++;
        $display("FAIL v%0d alarm: got %0b expected %0b", i, bus.alarm, tbl[i].a);
      end
      if (bus.digit_cnt !== tbl[i].c) begin
        n_fail++;
        $display("FAIL v%0d digit_cnt: got %0d expected %0d", i, bus.digit_cnt, tbl[i].c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
